// File: rtl/xif_master_pkg.sv
// Shared types for the CV-X-IF issue master: FSM state encoding and the captured offload record.
package xif_master_pkg;

  localparam int XIF_ID_W     = 4;
  localparam int XIF_ID_W_MAX = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    WB       = 2'd3
  } xif_state_e;

  // id is stored at its maximum width; the top slices it down to ID_W
  typedef struct packed {
    logic [31:0]             instr;
    logic [31:0]             rs0;
    logic [31:0]             rs1;
    logic [XIF_ID_W_MAX-1:0] id;
  } xif_offload_t;

endpackage

// File: rtl/xif_issue_master_if.sv
// Decode, issue, result and writeback signals of the issue master, grouped with master/slave views.
interface xif_issue_master_if
  import xif_master_pkg::*;
#(
  parameter int ID_W = XIF_ID_W
) ();
  logic            offload_valid_i;
  logic            offload_ready_o;
  logic [31:0]     offload_instr_i;
  logic [31:0]     offload_rs0_i;
  logic [31:0]     offload_rs1_i;
  logic [ID_W-1:0] offload_id_i;
  logic            issue_valid_o;
  logic            issue_ready_i;
  logic [31:0]     issue_instr_o;
  logic [31:0]     issue_rs0_o;
  logic [31:0]     issue_rs1_o;
  logic [ID_W-1:0] issue_id_o;
  logic            issue_accept_i;
  logic            issue_writeback_i;
  logic            result_valid_i;
  logic            result_ready_o;
  logic [ID_W-1:0] result_id_i;
  logic [4:0]      result_rd_i;
  logic [31:0]     result_data_i;
  logic            wb_valid_o;
  logic [4:0]      wb_rd_o;
  logic [31:0]     wb_data_o;
  logic            illegal_o;
  logic            timeout_o;
  logic            busy_o;

  modport master (
    input  offload_valid_i, offload_instr_i, offload_rs0_i, offload_rs1_i, offload_id_i,
           issue_ready_i, issue_accept_i, issue_writeback_i,
           result_valid_i, result_id_i, result_rd_i, result_data_i,
    output offload_ready_o, issue_valid_o, issue_instr_o, issue_rs0_o, issue_rs1_o, issue_id_o,
           result_ready_o, wb_valid_o, wb_rd_o, wb_data_o, illegal_o, timeout_o, busy_o
  );

  modport slave (
    output offload_valid_i, offload_instr_i, offload_rs0_i, offload_rs1_i, offload_id_i,
           issue_ready_i, issue_accept_i, issue_writeback_i,
           result_valid_i, result_id_i, result_rd_i, result_data_i,
    input  offload_ready_o, issue_valid_o, issue_instr_o, issue_rs0_o, issue_rs1_o, issue_id_o,
           result_ready_o, wb_valid_o, wb_rd_o, wb_data_o, illegal_o, timeout_o, busy_o
  );
endinterface

// File: rtl/xif_issue_master_timeout_cnt.sv
// Abort timer: counts enabled cycles since the last clear and flags the last allowed cycle.
module xif_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic w_unused_ok;
      assign w_unused_ok = i_clk ^ i_rst ^ i_clr ^ i_en;
      assign o_expired   = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      logic [CW-1:0] r_cnt;

      always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) r_cnt <= '0;
        else if (i_en)      r_cnt <= r_cnt + 1'b1;
      end

      assign o_expired = i_en && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/xif_issue_master.sv
// CV-X-IF issue master: one outstanding offload, result collection, register-file writeback.
// Build option XIF_ISSUE_MASTER_WB_BYPASS_EN: writeback driven in the result handshake cycle.
module xif_issue_master
  import xif_master_pkg::*;
#(
  parameter int ID_W           = XIF_ID_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  xif_issue_master_if.master  bus
);

  xif_state_e   r_state;
  xif_offload_t r_off;
  logic         r_offload_ready, r_issue_valid, r_result_ready, r_busy;
  logic         r_illegal, r_timeout;
  logic         w_expired, w_tmr_clr, w_tmr_en, w_id_match, w_issue_hs, w_res_hit;

  assign w_id_match = (bus.result_id_i == r_off.id[ID_W-1:0]);
  assign w_issue_hs = (r_state == ISSUE) && bus.issue_ready_i;
  assign w_res_hit  = (r_state == WAIT_RES) && bus.result_valid_i && w_id_match;
  assign w_tmr_en   = (r_state == ISSUE) || (r_state == WAIT_RES);
  assign w_tmr_clr  = ((r_state == IDLE) && bus.offload_valid_i) ||
                      (w_issue_hs && bus.issue_accept_i && bus.issue_writeback_i);

  xif_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmr (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

`ifndef XIF_ISSUE_MASTER_WB_BYPASS_EN
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= IDLE;
      r_off           <= '0;
      r_offload_ready <= 1'b1;
      r_issue_valid   <= 1'b0;
      r_result_ready  <= 1'b0;
      r_busy          <= 1'b0;
      r_illegal       <= 1'b0;
      r_timeout       <= 1'b0;
`ifndef XIF_ISSUE_MASTER_WB_BYPASS_EN
      r_wb_valid      <= 1'b0;
      r_wb_rd         <= '0;
      r_wb_data       <= '0;
`endif
    end else begin
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
`ifndef XIF_ISSUE_MASTER_WB_BYPASS_EN
      r_wb_valid <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (bus.offload_valid_i) begin
            r_off.instr     <= bus.offload_instr_i;
            r_off.rs0       <= bus.offload_rs0_i;
            r_off.rs1       <= bus.offload_rs1_i;
            r_off.id        <= XIF_ID_W_MAX'(bus.offload_id_i);
            r_state         <= ISSUE;
            r_offload_ready <= 1'b0;
            r_issue_valid   <= 1'b1;
            r_busy          <= 1'b1;
          end
        end
        ISSUE: begin
          // a handshake in the expiry cycle takes priority over the abort
          if (bus.issue_ready_i) begin
            r_issue_valid <= 1'b0;
            if (bus.issue_accept_i && bus.issue_writeback_i) begin
              r_state        <= WAIT_RES;
              r_result_ready <= 1'b1;
            end else begin
              r_state         <= IDLE;
              r_offload_ready <= 1'b1;
              r_busy          <= 1'b0;
              r_illegal       <= !bus.issue_accept_i;
            end
          end else if (w_expired) begin
            r_issue_valid   <= 1'b0;
            r_state         <= IDLE;
            r_offload_ready <= 1'b1;
            r_busy          <= 1'b0;
            r_timeout       <= 1'b1;
          end
        end
        WAIT_RES: begin
          // results with a foreign id are acknowledged and dropped
          if (w_res_hit) begin
            r_result_ready <= 1'b0;
`ifdef XIF_ISSUE_MASTER_WB_BYPASS_EN
            r_state         <= IDLE;
            r_offload_ready <= 1'b1;
            r_busy          <= 1'b0;
`else
            r_state    <= WB;
            r_wb_valid <= (bus.result_rd_i != 5'd0);
            r_wb_rd    <= bus.result_rd_i;
            r_wb_data  <= bus.result_data_i;
`endif
          end else if (w_expired) begin
            r_result_ready  <= 1'b0;
            r_state         <= IDLE;
            r_offload_ready <= 1'b1;
            r_busy          <= 1'b0;
            r_timeout       <= 1'b1;
          end
        end
        default: begin
          r_state         <= IDLE;
          r_offload_ready <= 1'b1;
          r_busy          <= 1'b0;
        end
      endcase
    end
  end

  assign bus.offload_ready_o = r_offload_ready;
  assign bus.issue_valid_o   = r_issue_valid;
  assign bus.issue_instr_o   = r_off.instr;
  assign bus.issue_rs0_o     = r_off.rs0;
  assign bus.issue_rs1_o     = r_off.rs1;
  assign bus.issue_id_o      = r_off.id[ID_W-1:0];
  assign bus.result_ready_o  = r_result_ready;
  assign bus.illegal_o       = r_illegal;
  assign bus.timeout_o       = r_timeout;
  assign bus.busy_o          = r_busy;

`ifdef XIF_ISSUE_MASTER_WB_BYPASS_EN
  assign bus.wb_valid_o = w_res_hit && (bus.result_rd_i != 5'd0);
  assign bus.wb_rd_o    = w_res_hit ? bus.result_rd_i : 5'd0;
  assign bus.wb_data_o  = w_res_hit ? bus.result_data_i : 32'd0;
`else
  assign bus.wb_valid_o = r_wb_valid;
  assign bus.wb_rd_o    = r_wb_rd;
  assign bus.wb_data_o  = r_wb_data;
`endif

endmodule
